// File: rtl/tap_and_uul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tap_and_uul_pkg
//  Description : Shared definitions for the JTAG TAP + unit-under-logic block:
//                TAP state encoding, instruction opcodes, register widths and
//                the UUL core adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package tap_and_uul_pkg;

   localparam int IR_WIDTH  = 3;
   localparam int BSR_WIDTH = 10;
   localparam int PIN_W     = 6;   // boundary input cells
   localparam int POUT_W    = 4;   // boundary output cells

   // Standard IEEE 1149.1 state encoding, explicit 4-bit width.
   typedef enum logic [3:0] {
      TAP_EX2DR   = 4'h0,
      TAP_EX1DR   = 4'h1,
      TAP_SHDR    = 4'h2,
      TAP_PAUSEDR = 4'h3,
      TAP_SELIR   = 4'h4,
      TAP_UPDR    = 4'h5,
      TAP_CAPDR   = 4'h6,
      TAP_SELDR   = 4'h7,
      TAP_EX2IR   = 4'h8,
      TAP_EX1IR   = 4'h9,
      TAP_SHIR    = 4'hA,
      TAP_PAUSEIR = 4'hB,
      TAP_RTI     = 4'hC,
      TAP_UPIR    = 4'hD,
      TAP_CAPIR   = 4'hE,
      TAP_TLR     = 4'hF
   } tap_state_t;

   localparam logic [IR_WIDTH-1:0] OP_EXTEST = 3'b000;
   localparam logic [IR_WIDTH-1:0] OP_SAMPLE = 3'b010;
   localparam logic [IR_WIDTH-1:0] OP_BYPASS = 3'b110;

   // UUL core: low 3-bit field plus high 3-bit field, carry kept in bit 3.
   function automatic logic [POUT_W-1:0] uul_sum(input logic [PIN_W-1:0] p);
      return {1'b0, p[2:0]} + {1'b0, p[5:3]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/tap_and_uul_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tap_fsm
//  Description : IEEE 1149.1 16-state TAP controller. Advances on TCK rise,
//                async active-low reset to Test-Logic-Reset. Decodes the
//                per-path capture/shift/update strobes from the current state.
//  Ports       : i_tck, i_trst_n, i_tms        - JTAG clock/reset/mode
//                o_tlr                         - in Test-Logic-Reset
//                o_capture_ir/o_shift_ir/o_update_ir
//                o_capture_dr/o_shift_dr/o_update_dr
//  Revision    : 1.0 - initial release
// ============================================================================
module tap_fsm
   import tap_and_uul_pkg::*;
(
   input  logic i_tck,
   input  logic i_trst_n,
   input  logic i_tms,
   output logic o_tlr,
   output logic o_capture_ir,
   output logic o_shift_ir,
   output logic o_update_ir,
   output logic o_capture_dr,
   output logic o_shift_dr,
   output logic o_update_dr
);

   tap_state_t state_q;
   tap_state_t state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         TAP_TLR     : state_d = i_tms ? TAP_TLR   : TAP_RTI;
         TAP_RTI     : state_d = i_tms ? TAP_SELDR : TAP_RTI;
         TAP_SELDR   : state_d = i_tms ? TAP_SELIR : TAP_CAPDR;
         TAP_CAPDR   : state_d = i_tms ? TAP_EX1DR : TAP_SHDR;
         TAP_SHDR    : state_d = i_tms ? TAP_EX1DR : TAP_SHDR;
         TAP_EX1DR   : state_d = i_tms ? TAP_UPDR  : TAP_PAUSEDR;
         TAP_PAUSEDR : state_d = i_tms ? TAP_EX2DR : TAP_PAUSEDR;
         TAP_EX2DR   : state_d = i_tms ? TAP_UPDR  : TAP_SHDR;
         TAP_UPDR    : state_d = i_tms ? TAP_SELDR : TAP_RTI;
         TAP_SELIR   : state_d = i_tms ? TAP_TLR   : TAP_CAPIR;
         TAP_CAPIR   : state_d = i_tms ? TAP_EX1IR : TAP_SHIR;
         TAP_SHIR    : state_d = i_tms ? TAP_EX1IR : TAP_SHIR;
         TAP_EX1IR   : state_d = i_tms ? TAP_UPIR  : TAP_PAUSEIR;
         TAP_PAUSEIR : state_d = i_tms ? TAP_EX2IR : TAP_PAUSEIR;
         TAP_EX2IR   : state_d = i_tms ? TAP_UPIR  : TAP_SHIR;
         TAP_UPIR    : state_d = i_tms ? TAP_SELDR : TAP_RTI;
         default     : state_d = TAP_TLR;
      endcase
   end

   always_ff @(posedge i_tck or negedge i_trst_n) begin
      if (!i_trst_n) state_q <= TAP_TLR;
      else           state_q <= state_d;
   end

   assign o_tlr        = (state_q == TAP_TLR);
   assign o_capture_ir = (state_q == TAP_CAPIR);
   assign o_shift_ir   = (state_q == TAP_SHIR);
   assign o_update_ir  = (state_q == TAP_UPIR);
   assign o_capture_dr = (state_q == TAP_CAPDR);
   assign o_shift_dr   = (state_q == TAP_SHDR);
   assign o_update_dr  = (state_q == TAP_UPDR);

endmodule
`default_nettype wire

// File: rtl/tap_and_uul.sv
`default_nettype none
// ============================================================================
//  Module      : tap_and_uul
//  Description : JTAG boundary-scan wrapper around a 3+3 bit adder (the UUL).
//                Holds the IR, 10-cell BSR (6 input + 4 output cells), bypass
//                bit and the TDO mux; the TAP FSM lives in tap_fsm.
//  Ports       : TCK/TRST_n/TMS/TDI/TDO    - JTAG port
//                TDI2/TCK2/TMS2/TDO2       - probe copies of the JTAG pins
//                Par_in[5:0]               - UUL input pins
//                Par_out[3:0]              - UUL output pins
//                clk_50MHz                 - board clock, not used here
//  Revision    : 1.0 - initial release
// ============================================================================
module tap_and_uul
   import tap_and_uul_pkg::*;
#(
   parameter int IR_W  = IR_WIDTH,
   parameter int BSR_W = BSR_WIDTH
) (
   input  logic              TCK,
   input  logic              TRST_n,
   input  logic              TMS,
   input  logic              TDI,
   output logic              TDO,
   output logic              TDI2,
   output logic              TCK2,
   output logic              TMS2,
   output logic              TDO2,
   input  logic [PIN_W-1:0]  Par_in,
   output logic [POUT_W-1:0] Par_out,
   input  logic              clk_50MHz
);

   logic unused_clk;
   assign unused_clk = clk_50MHz;

   logic tlr, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr;

   tap_fsm u_fsm (
      .i_tck        (TCK),
      .i_trst_n     (TRST_n),
      .i_tms        (TMS),
      .o_tlr        (tlr),
      .o_capture_ir (capture_ir),
      .o_shift_ir   (shift_ir),
      .o_update_ir  (update_ir),
      .o_capture_dr (capture_dr),
      .o_shift_dr   (shift_dr),
      .o_update_dr  (update_dr)
   );

   logic [IR_W-1:0]   ir_shift_q,  ir_shift_d;
   logic [IR_W-1:0]   instr_q,     instr_d;
   logic [BSR_W-1:0]  bsr_shift_q, bsr_shift_d;
   logic [BSR_W-1:0]  bsr_latch_q, bsr_latch_d;
   logic              bypass_q,    bypass_d;
   logic              tdo_q,       tdo_d;

   logic [POUT_W-1:0] uul_result;
   logic              is_extest;
   logic              bsr_sel;

   assign uul_result = uul_sum(Par_in);
   assign is_extest  = (instr_q == OP_EXTEST);
   // Only EXTEST and SAMPLE select the BSR; every other code is BYPASS.
   assign bsr_sel    = is_extest || (instr_q == OP_SAMPLE);

   // ---------------- rising-edge registers: capture and shift -------------
   always_comb begin
      ir_shift_d  = ir_shift_q;
      bsr_shift_d = bsr_shift_q;
      bypass_d    = bypass_q;

      if (capture_ir)     ir_shift_d = IR_W'(1);
      else if (shift_ir)  ir_shift_d = {TDI, ir_shift_q[IR_W-1:1]};

      if (capture_dr && bsr_sel)     bsr_shift_d = {uul_result, Par_in};
      else if (shift_dr && bsr_sel)  bsr_shift_d = {TDI, bsr_shift_q[BSR_W-1:1]};

      if (capture_dr)     bypass_d = 1'b0;
      else if (shift_dr)  bypass_d = TDI;
   end

   always_ff @(posedge TCK or negedge TRST_n) begin
      if (!TRST_n) begin
         ir_shift_q  <= '0;
         bsr_shift_q <= '0;
         bypass_q    <= 1'b0;
      end else begin
         ir_shift_q  <= ir_shift_d;
         bsr_shift_q <= bsr_shift_d;
         bypass_q    <= bypass_d;
      end
   end

   // ---------------- falling-edge registers: update and TDO ---------------
   always_comb begin
      instr_d     = instr_q;
      bsr_latch_d = bsr_latch_q;
      tdo_d       = 1'b0;

      // TLR wins so the instruction is BYPASS whenever the TAP sits in reset.
      if (tlr)             instr_d = OP_BYPASS;
      else if (update_ir)  instr_d = ir_shift_q;

      if (update_dr && bsr_sel) bsr_latch_d = bsr_shift_q;

      if (shift_ir)       tdo_d = ir_shift_q[0];
      else if (shift_dr)  tdo_d = bsr_sel ? bsr_shift_q[0] : bypass_q;
   end

   always_ff @(negedge TCK or negedge TRST_n) begin
      if (!TRST_n) begin
         instr_q     <= OP_BYPASS;
         bsr_latch_q <= '0;
         tdo_q       <= 1'b0;
      end else begin
         instr_q     <= instr_d;
         bsr_latch_q <= bsr_latch_d;
         tdo_q       <= tdo_d;
      end
   end

   // ---------------- outputs ----------------------------------------------
   assign Par_out = is_extest ? bsr_latch_q[BSR_W-1 -: POUT_W] : uul_result;
   assign TDO     = tdo_q;
   assign TDI2    = TDI;
   assign TCK2    = TCK;
   assign TMS2    = TMS;
   assign TDO2    = tdo_q;

endmodule
`default_nettype wire

// File: tb/tb_tap_and_uul.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tap_and_uul
//  Description : Self-checking bench for tap_and_uul. Drives whole IR/DR scans
//                and compares against a transaction-level model of the
//                instruction, update latch, TDO stream and Par_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tap_and_uul;
   import tap_and_uul_pkg::*;

   logic       TCK = 1'b0;
   logic       TRST_n = 1'b0;
   logic       TMS = 1'b1;
   logic       TDI = 1'b0;
   logic       clk_50MHz = 1'b0;
   logic [5:0] Par_in = 6'd0;
   logic       TDO, TDI2, TCK2, TMS2, TDO2;
   logic [3:0] Par_out;

   always #5  TCK = ~TCK;
   always #10 clk_50MHz = ~clk_50MHz;

   tap_and_uul dut (
      .TCK       (TCK),
      .TRST_n    (TRST_n),
      .TMS       (TMS),
      .TDI       (TDI),
      .TDO       (TDO),
      .TDI2      (TDI2),
      .TCK2      (TCK2),
      .TMS2      (TMS2),
      .TDO2      (TDO2),
      .Par_in    (Par_in),
      .Par_out   (Par_out),
      .clk_50MHz (clk_50MHz)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [2:0] m_instr;
   logic [9:0] m_latch;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int core_val();
      return int'(Par_in[2:0]) + int'(Par_in[5:3]);
   endfunction

   function automatic logic [3:0] exp_par_out();
      return (m_instr == 3'b000) ? m_latch[9:6] : 4'(core_val());
   endfunction

   function automatic logic uses_bsr(input logic [2:0] op);
      return (op == 3'b000) || (op == 3'b010);
   endfunction

   // One TCK period: drive before the rise, sample TDO after the fall.
   task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
      TMS = tms;
      TDI = tdi;
      @(posedge TCK);
      @(negedge TCK);
      #1 tdo = TDO;
   endtask

   // From RTI: full IR scan of a 3-bit code, back to RTI.
   task automatic scan_ir(input logic [2:0] code);
      logic       t;
      logic [2:0] dout;
      tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      dout[0] = t;
      for (int i = 0; i < 3; i++) begin
         tck_cycle(i == 2, code[i], t);
         if (i < 2) dout[i+1] = t;
      end
      tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      m_instr = code;
      check_eq("ir_capture_out", 32'(dout), 32'(3'b001));
      check_eq("ir_instr", 32'(dut.instr_q), 32'(code));
      check_eq("ir_par_out", 32'(Par_out), 32'(exp_par_out()));
   endtask

   // From RTI: full 10-bit DR scan, back to RTI.
   task automatic scan_dr(input logic [9:0] din, output logic [9:0] dout);
      logic       t;
      logic [9:0] cap;
      logic [9:0] exp;
      cap = (10'(core_val()) << 6) | {4'b0, Par_in};
      tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      dout[0] = t;
      for (int i = 0; i < 10; i++) begin
         tck_cycle(i == 9, din[i], t);
         if (i < 9) dout[i+1] = t;
      end
      tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      if (uses_bsr(m_instr)) begin
         exp     = cap;
         m_latch = din;
      end else begin
         exp = {din[8:0], 1'b0};
      end
      check_eq("dr_out", 32'(dout), 32'(exp));
      check_eq("dr_par_out", 32'(Par_out), 32'(exp_par_out()));
   endtask

   // From RTI: enter ShDR, then five TMS=1 rises to TLR, then back to RTI.
   task automatic tlr_from_shdr();
      logic       t;
      logic [9:0] cap;
      cap = (10'(core_val()) << 6) | {4'b0, Par_in};
      tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, t);
      // The exit path passes through UpDR after one shift of TDI=0.
      if (uses_bsr(m_instr)) m_latch = {1'b0, cap[9:1]};
      m_instr = 3'b110;
      check_eq("tlr_state", 32'(dut.u_fsm.state_q), 32'(TAP_TLR));
      check_eq("tlr_instr", 32'(dut.instr_q), 32'(3'b110));
      check_eq("tlr_par_out", 32'(Par_out), 32'(exp_par_out()));
      tck_cycle(1'b0, 1'b0, t);
   endtask

   // From RTI: enter ShIR, shift one bit, pull TRST_n low mid-scan.
   task automatic reset_mid_shir();
      logic t;
      tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      tck_cycle(1'b0, 1'($urandom_range(0, 1)), t);
      TRST_n = 1'b0;
      #1;
      m_instr = 3'b110;
      m_latch = 10'd0;
      check_eq("rst_state", 32'(dut.u_fsm.state_q), 32'(TAP_TLR));
      check_eq("rst_instr", 32'(dut.instr_q), 32'(3'b110));
      check_eq("rst_tdo", 32'(TDO), 32'(0));
      check_eq("rst_par_out", 32'(Par_out), 32'(exp_par_out()));
      @(negedge TCK);
      #1 TRST_n = 1'b1;
      tck_cycle(1'b0, 1'b0, t);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       t;
      logic [9:0] dout;
      logic [2:0] op;

      m_instr = 3'b110;
      m_latch = 10'd0;
      Par_in  = 6'($urandom);

      // Held in reset
      #12;
      check_eq("reset_state", 32'(dut.u_fsm.state_q), 32'(TAP_TLR));
      check_eq("reset_instr", 32'(dut.instr_q), 32'(3'b110));
      check_eq("reset_tdo", 32'(TDO), 32'(0));
      check_eq("reset_par_out", 32'(Par_out), 32'(exp_par_out()));
      check_eq("probe_copies", 32'({TDI2, TMS2, TDO2}), 32'({TDI, TMS, TDO}));
      @(negedge TCK);
      #1 TRST_n = 1'b1;
      tck_cycle(1'b0, 1'b0, t);

      // Load SAMPLE (bits 0,1,0)
      scan_ir(3'b010);

      // SAMPLE stream with Par_in = 011_101, core = 8
      Par_in = 6'b011_101;
      scan_dr(10'd0, dout);
      check_eq("sample_stream", 32'(dout), 32'(10'b1000_011101));

      // Preload then EXTEST
      scan_dr(10'b01_0010_0000, dout);
      scan_ir(3'b000);
      check_eq("extest_par_out", 32'(Par_out), 32'(4'b0100));

      // BYPASS (bits 0,1,1): pattern 1,0,1 returns one TCK late
      scan_ir(3'b110);
      scan_dr({7'($urandom), 3'b101}, dout);
      check_eq("bypass_delay", 32'(dout[3:0]), 32'(4'b1010));

      // TLR from ShDR under SAMPLE, then mid-IR-shift reset under EXTEST
      scan_ir(3'b010);
      tlr_from_shdr();
      scan_ir(3'b000);
      reset_mid_shir();
      check_eq("rst_latch_kept_clear", 32'(dut.bsr_latch_q), 32'(0));

      // Randomised mix of operations
      for (int it = 0; it < 60; it++) begin
         Par_in = 6'($urandom);
         case ($urandom_range(0, 5))
            0, 1: begin
               case ($urandom_range(0, 3))
                  0:       op = 3'b000;
                  1:       op = 3'b010;
                  2:       op = 3'b110;
                  default: op = 3'($urandom);
               endcase
               scan_ir(op);
            end
            2, 3: scan_dr(10'($urandom), dout);
            4:    tlr_from_shdr();
            default: reset_mid_shir();
         endcase
         check_eq("rand_par_out", 32'(Par_out), 32'(exp_par_out()));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
